// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state codes, field positions, ALU ops.
// Also holds the default PC width.
package fetch_sequencer_pkg;

    localparam int DEF_PC_W = 10;

    // Instruction word layout: [8:4] opcode, [3:0] operand
    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 4;
    localparam int OPR_MSB = 3;
    localparam int OPR_LSB = 0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef enum logic [4:0] {
        ALU_NOP = 5'd0,
        ALU_ADD = 5'd1,
        ALU_SUB = 5'd2,
        ALU_AND = 5'd3,
        ALU_OR  = 5'd4,
        ALU_XOR = 5'd5,
        ALU_SHL = 5'd6,
        ALU_SHR = 5'd7
    } alu_op_e;

endpackage

// File: rtl/fetch_sequencer_branch_lut.sv
// Branch offset table: 4-bit operand index to a signed PC-relative offset.
// Entry 0 is zero so a branch through it spins on the same PC.
module branch_lut
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
) (
    input  logic [3:0]             idx,
    output logic signed [PC_W-1:0] offset
);

    logic signed [7:0] off8;

    always_comb begin
        off8 = 8'sd0;
        case (idx)
            4'd0:  off8 = 8'sd0;
            4'd1:  off8 = -8'sd4;
            4'd2:  off8 = 8'sd8;
            4'd3:  off8 = 8'sd1;
            4'd4:  off8 = 8'sd2;
            4'd5:  off8 = -8'sd1;
            4'd6:  off8 = 8'sd16;
            4'd7:  off8 = -8'sd16;
            4'd8:  off8 = 8'sd3;
            4'd9:  off8 = -8'sd2;
            4'd10: off8 = 8'sd32;
            4'd11: off8 = -8'sd32;
            4'd12: off8 = 8'sd5;
            4'd13: off8 = -8'sd8;
            4'd14: off8 = 8'sd64;
            default: off8 = -8'sd64;
        endcase
        offset = PC_W'(off8);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/RUN/HALTED FSM driving the ROM address,
// decoding opcode/operand and counting retired instructions.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = 9,
    parameter int CT_W    = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic [INSTR_W-1:0] INSTR,
    input  logic               BRANCH,
    input  logic               HALT,
    input  logic               ZERO,
    output logic [PC_W-1:0]    PC,
    output logic [4:0]         OPCODE,
    output logic [3:0]         OPERAND,
    output logic               OP_VALID,
    output logic               DONE,
    output logic [CT_W-1:0]    INSTR_CT
);

    logic [1:0]             state_q, state_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [CT_W-1:0]        ct_q, ct_d;
    logic                   done_q, done_d;
    logic signed [PC_W-1:0] br_off;

    function automatic logic [CT_W-1:0] sat_inc(input logic [CT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    branch_lut #(.PC_W(PC_W)) u_branch_lut (
        .idx    (INSTR[OPR_MSB:OPR_LSB]),
        .offset (br_off)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ct_d    = ct_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    ct_d    = '0;
                end
            end
            ST_RUN: begin
                // Every RUN edge retires the current instruction, including a halting one
                ct_d = sat_inc(ct_q);
                if (HALT) begin
                    state_d = ST_HALTED;
                    done_d  = 1'b1;
                end else if (BRANCH && ZERO) begin
                    pc_d = pc_q + $unsigned(br_off);
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            ST_HALTED: begin
                if (START) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    ct_d    = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
        end
    end

    // Decode outputs follow the ROM combinationally, gated to zero outside RUN
    assign OP_VALID = (state_q == ST_RUN);
    assign OPCODE   = OP_VALID ? INSTR[OPC_MSB:OPC_LSB] : 5'd0;
    assign OPERAND  = OP_VALID ? INSTR[OPR_MSB:OPR_LSB] : 4'd0;
    assign PC       = pc_q;
    assign DONE     = done_q;
    assign INSTR_CT = ct_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, meaning the program-counter width.
REQ-002 The block SHALL have parameter INSTR_W, default 9, meaning the instruction width: [8:4] opcode, [3:0] operand.
REQ-003 The block SHALL have parameter CT_W, default 16, meaning the retired-instruction counter width.
REQ-004 Ports SHALL be:
 - CLK  in  1  single clock, all state on rising edge
 - RST_N  in  1  reset, asynchronous, active-low
 - START  in  1  request to begin execution at PC 0
 - INSTR  in  INSTR_W  instruction word from combinational instruction ROM at address PC
 - BRANCH  in  1  branch request from the opcode decoder
 - HALT  in  1  halt request from the opcode decoder
 - ZERO  in  1  ALU zero flag, branch condition
 - PC  out  PC_W  instruction ROM address
 - OPCODE  out  5  opcode presented to the decoder
 - OPERAND  out  4  INSTR[3:0] pass-through
 - OP_VALID  out  1  OPCODE is a live instruction this cycle
 - DONE  out  1  program has halted
 - INSTR_CT  out  CT_W  retired-instruction count

Function
REQ-005 The FSM SHALL have states IDLE, RUN and HALTED.
REQ-006 In IDLE, START=1 SHALL move the FSM to RUN with PC=0 on the next edge; START=0 SHALL hold IDLE.
REQ-007 In RUN, OP_VALID SHALL be 1, OPCODE SHALL equal INSTR[8:4] and OPERAND SHALL equal INSTR[3:0], all combinationally.
REQ-008 Outside RUN, OP_VALID SHALL be 0 and OPCODE and OPERAND SHALL be 0.
REQ-009 In RUN, each edge SHALL retire one instruction and INSTR_CT SHALL increment by 1, saturating at all-ones.
REQ-010 In RUN with HALT=1, on the next edge the FSM SHALL enter HALTED, PC SHALL hold, and the halting instruction SHALL count as retired.
REQ-011 In RUN with HALT=0, BRANCH=1 and ZERO=1, PC SHALL become PC + sign-extended offset from branch_lut[OPERAND], modulo 2^PC_W.
REQ-012 In RUN with HALT=0 and not taken (BRANCH=0 or ZERO=0), PC SHALL become PC+1, wrapping 2^PC_W-1 -> 0.
REQ-013 HALT SHALL take priority over BRANCH when both are asserted.
REQ-014 START SHALL be ignored while in RUN.
REQ-015 DONE SHALL be 1 exactly while in HALTED, registered, asserting on the edge that enters HALTED.
REQ-016 In HALTED, START=1 SHALL return the FSM to RUN on the next edge with PC=0 and INSTR_CT cleared to 0.
REQ-017 BRANCH, HALT and ZERO SHALL be ignored outside RUN.
REQ-018 A branch offset of 0 SHALL re-execute the same PC (legal spin loop).

Reset
REQ-019 While RST_N=0, the block SHALL asynchronously force state=IDLE, PC=0, INSTR_CT=0, DONE=0, OP_VALID=0, OPCODE=0 and OPERAND=0.
REQ-020 Reset asserted mid-RUN SHALL abandon the program with no further retirement; after release the FSM SHALL wait in IDLE for START.

Structure
REQ-021 The state enum, PC_W and opcode field positions SHALL live in the shared definitions package alongside the ALU-op enum.
REQ-022 Branch offsets SHALL come from a sub-module branch_lut: a combinational 16-entry table, 4-bit index, signed PC_W-bit offset.

Verification
REQ-023 Reset, then START pulse -> RUN next edge, PC=0, OP_VALID=1; with no branches, PC=0,1,2,3 on successive edges.
REQ-024 At PC=5 with BRANCH=1, ZERO=1, lut[2]=+8 and OPERAND=2 -> PC=13 next edge; the same case with ZERO=0 -> PC=6.
REQ-025 At PC=3, lut[1]=-4 and a taken branch -> PC=1023 (wrap); at PC=1023, not taken -> PC=0.
REQ-026 HALT and BRANCH both asserted at PC=7 after 7 retirements -> HALTED, PC=7, DONE=1, INSTR_CT=8, OP_VALID=0; a START pulse then gives RUN, PC=0, INSTR_CT=0, DONE=0.
REQ-027 RST_N driven low mid-cycle during RUN at PC=40 -> outputs zero immediately without waiting for a clock edge; after release, FSM stays IDLE until START.
REQ-028 INSTR_CT preloaded near 0xFFFF by running 65540 instructions -> INSTR_CT holds 0xFFFF.
